// File: rtl/sysmem_rr_arbiter.sv
// sysmem_rr_arbiter: N-requester round-robin arbiter and sequencer in front of
// the single System Memory port. One transaction is in flight at a time: the
// winner's request is captured, replayed to SysMem, and the response (or a
// watchdog timeout) is returned to the requester that owns the grant.
module sysmem_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic                         clk_in,
  input  logic                         reset_in,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_rdy,
  input  logic [NUM_REQ-1:0]           req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wr_data,
  output logic [NUM_REQ-1:0]           ack_valid,
  input  logic [NUM_REQ-1:0]           ack_rdy,
  output logic [DATA_W-1:0]            ack_data,
  output logic                         ack_err,
  output logic                         sm_req_valid,
  input  logic                         sm_req_rdy,
  output logic                         sm_req_rw,
  output logic [ADDR_W-1:0]            sm_req_addr,
  output logic [DATA_W-1:0]            sm_req_wr_data,
  input  logic                         sm_ack_valid,
  output logic                         sm_ack_rdy,
  input  logic [DATA_W-1:0]            sm_ack_rd_data,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy
);

  // Width of a requester index and of the watchdog counter. The counter only
  // ever has to hold values up to TIMEOUT-1 before the timeout fires.
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]      CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GW-1:0]      PTR_INIT = GW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SM_REQ = 2'd1,
    SM_ACK = 2'd2,
    RSP    = 2'd3
  } state_t;

  state_t              state;
  logic [GW-1:0]       last_grant;
  logic                cap_rw;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_data;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_err;
  logic [CW-1:0]       wd_cnt;

  // Unpacked views of the packed per-requester payload buses
  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = req_wr_data[g*DATA_W +: DATA_W];
  end

  // Round-robin winner selection
  logic                found;
  logic [GW-1:0]       winner;
  logic [GW-1:0]       cand;
  int                  idx;

  // Scan requesters starting just after the last owner, wrapping modulo NUM_REQ
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx  = (int'(last_grant) + k) % NUM_REQ;
      cand = GW'(idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // The grant is visible combinationally in IDLE only; it is also held at zero
  // while reset is asserted so every output is quiet during reset.
  assign req_rdy = (state == IDLE && found && reset_in) ? (ONE << winner) : '0;

  assign sm_req_rw      = cap_rw;
  assign sm_req_addr    = cap_addr;
  assign sm_req_wr_data = cap_data;
  assign ack_data       = rsp_data;
  assign ack_err        = rsp_err;

  // Transaction sequencer: state, captured request, watchdog and registered handshakes
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state        <= IDLE;
      last_grant   <= PTR_INIT;
      grant_id     <= '0;
      cap_rw       <= 1'b0;
      cap_addr     <= '0;
      cap_data     <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      wd_cnt       <= '0;
      sm_req_valid <= 1'b0;
      sm_ack_rdy   <= 1'b0;
      ack_valid    <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            cap_rw       <= req_rw[winner];
            cap_addr     <= addr_arr[winner];
            cap_data     <= data_arr[winner];
            grant_id     <= winner;
            last_grant   <= winner;
            sm_req_valid <= 1'b1;
            busy         <= 1'b1;
            state        <= SM_REQ;
          end
        end

        SM_REQ: begin
          if (sm_req_rdy) begin
            sm_req_valid <= 1'b0;
            sm_ack_rdy   <= 1'b1;
            wd_cnt       <= '0;
            state        <= SM_ACK;
          end
        end

        SM_ACK: begin
          if (sm_ack_valid) begin
            rsp_data   <= cap_rw ? sm_ack_rd_data : '0;
            rsp_err    <= 1'b0;
            sm_ack_rdy <= 1'b0;
            ack_valid  <= ONE << grant_id;
            state      <= RSP;
          end else if (TIMEOUT != 0 && wd_cnt == CNT_LAST) begin
            rsp_data   <= '0;
            rsp_err    <= 1'b1;
            sm_ack_rdy <= 1'b0;
            ack_valid  <= ONE << grant_id;
            state      <= RSP;
          end else if (TIMEOUT != 0) begin
            wd_cnt     <= wd_cnt + CW'(1);
          end
        end

        RSP: begin
          if (ack_rdy[grant_id]) begin
            ack_valid <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysmem_rr_arbiter.sv
// tb_sysmem_rr_arbiter: scoreboard bench for the round-robin SysMem arbiter.
// Requests push expected SysMem requests and responses into queues; a SysMem
// responder and a response monitor pop and compare them independently.
module tb_sysmem_rr_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int TO = 7;

  logic                  clk_in = 1'b0;
  logic                  reset_in;
  logic [NR-1:0]         req_valid;
  logic [NR-1:0]         req_rdy;
  logic [NR-1:0]         req_rw;
  logic [NR*AW-1:0]      req_addr;
  logic [NR*DW-1:0]      req_wr_data;
  logic [NR-1:0]         ack_valid;
  logic [NR-1:0]         ack_rdy;
  logic [DW-1:0]         ack_data;
  logic                  ack_err;
  logic                  sm_req_valid;
  logic                  sm_req_rdy;
  logic                  sm_req_rw;
  logic [AW-1:0]         sm_req_addr;
  logic [DW-1:0]         sm_req_wr_data;
  logic                  sm_ack_valid;
  logic                  sm_ack_rdy;
  logic [DW-1:0]         sm_ack_rd_data;
  logic [$clog2(NR)-1:0] grant_id;
  logic                  busy;

  always #5 clk_in = ~clk_in;

  sysmem_rr_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .req_valid      (req_valid),
    .req_rdy        (req_rdy),
    .req_rw         (req_rw),
    .req_addr       (req_addr),
    .req_wr_data    (req_wr_data),
    .ack_valid      (ack_valid),
    .ack_rdy        (ack_rdy),
    .ack_data       (ack_data),
    .ack_err        (ack_err),
    .sm_req_valid   (sm_req_valid),
    .sm_req_rdy     (sm_req_rdy),
    .sm_req_rw      (sm_req_rw),
    .sm_req_addr    (sm_req_addr),
    .sm_req_wr_data (sm_req_wr_data),
    .sm_ack_valid   (sm_ack_valid),
    .sm_ack_rdy     (sm_ack_rdy),
    .sm_ack_rd_data (sm_ack_rd_data),
    .grant_id       (grant_id),
    .busy           (busy)
  );

  typedef struct {
    int            id;
    logic          err;
    logic [DW-1:0] data;
  } rsp_t;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } smr_t;

  rsp_t rsp_q[$];
  smr_t sm_q[$];

  int checks = 0;
  int errors = 0;
  int model_ptr = NR - 1;
  int force_req_wait = -1;
  int force_ack_wait = -1;
  bit suppress_ack = 1'b0;
  bit ack_random = 1'b0;
  logic [NR-1:0] ack_fixed = '0;

  // SysMem contents as a pure function of the address
  function automatic logic [DW-1:0] memLine(input logic [AW-1:0] a);
    logic [AW-1:0] h;
    if (a == 32'h0000_1000) return {32{8'hA5}};
    h = (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    return {8{h}};
  endfunction

  function automatic logic [DW-1:0] randLine();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one request and record what SysMem and the requester should see
  task automatic applyStimulus(input int id, input logic rw, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input bit exp_to);
    rsp_t r;
    smr_t s;
    req_valid[id]              = 1'b1;
    req_rw[id]                 = rw;
    req_addr[id*AW +: AW]      = addr;
    req_wr_data[id*DW +: DW]   = data;
    s.rw   = rw;
    s.addr = addr;
    s.data = data;
    sm_q.push_back(s);
    r.id   = id;
    r.err  = exp_to;
    r.data = (exp_to || !rw) ? '0 : memLine(addr);
    rsp_q.push_back(r);
    model_ptr = id;
  endtask

  // Simultaneous requests are served in round-robin order after the last owner
  task automatic issueMask(input logic [NR-1:0] mask);
    int start;
    int idx;
    start = model_ptr;
    for (int k = 1; k <= NR; k++) begin
      idx = (start + k) % NR;
      if (mask[idx]) applyStimulus(idx, 1'($urandom), $urandom, randLine(), 1'b0);
    end
  endtask

  // One clock: drop granted requests, then drive the next ack_rdy pattern
  task automatic cycle();
    logic [NR-1:0] g;
    @(negedge clk_in);
    g = req_rdy;
    @(posedge clk_in);
    #1;
    req_valid = req_valid & ~g;
    ack_rdy   = ack_random ? NR'($urandom) : ack_fixed;
  endtask

  task automatic serviceAll();
    int budget;
    budget = 0;
    while (rsp_q.size() != 0 && budget < 3000) begin
      cycle();
      budget++;
    end
    checkOutput("service_outstanding", DW'(rsp_q.size()), '0);
    rsp_q.delete();
    sm_q.delete();
  endtask

  // SysMem responder: checks each request, then answers after a wait
  initial begin : responder
    smr_t seen;
    smr_t e;
    int   wq;
    int   wa;
    sm_req_rdy     = 1'b0;
    sm_ack_valid   = 1'b0;
    sm_ack_rd_data = '0;
    forever begin
      @(negedge clk_in);
      if (reset_in && sm_req_valid) begin
        seen.rw   = sm_req_rw;
        seen.addr = sm_req_addr;
        seen.data = sm_req_wr_data;
        wq = (force_req_wait >= 0) ? force_req_wait : int'($urandom_range(0, 3));
        for (int w = 0; w < wq; w++) begin
          @(negedge clk_in);
          if (reset_in) begin
            checkOutput("sm_req_stable", DW'({sm_req_valid, sm_req_rw, sm_req_addr}),
                        DW'({1'b1, seen.rw, seen.addr}));
            checkOutput("sm_wr_data_stable", sm_req_wr_data, seen.data);
          end
        end
        sm_req_rdy = 1'b1;
        if (sm_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sm_unexpected_req: got addr 0x%0h, expected no request", seen.addr);
        end else begin
          e = sm_q.pop_front();
          checkOutput("sm_req_rw_addr", DW'({seen.rw, seen.addr}), DW'({e.rw, e.addr}));
          checkOutput("sm_req_wr_data", seen.data, e.data);
        end
        @(negedge clk_in);
        sm_req_rdy = 1'b0;
        if (suppress_ack) begin
          repeat (TO + 4) @(negedge clk_in);
          if (reset_in) checkOutput("stray_ack_not_ready", DW'(sm_ack_rdy), '0);
          sm_ack_valid   = 1'b1;
          sm_ack_rd_data = randLine();
          @(negedge clk_in);
          sm_ack_valid   = 1'b0;
        end else begin
          wa = (force_ack_wait >= 0) ? force_ack_wait : int'($urandom_range(0, 4));
          repeat (wa) @(negedge clk_in);
          if (reset_in) checkOutput("sm_ack_rdy", DW'(sm_ack_rdy), DW'(1'b1));
          sm_ack_valid   = 1'b1;
          sm_ack_rd_data = seen.rw ? memLine(seen.addr) : randLine();
          @(negedge clk_in);
          sm_ack_valid   = 1'b0;
        end
      end
    end
  end

  // Response monitor: compares every presented response with the queue head
  initial begin : monitor
    rsp_t          r;
    logic [NR-1:0] oh;
    forever begin
      @(negedge clk_in);
      if (reset_in) begin
        checkOutput("req_rdy_onehot0", DW'($onehot0(req_rdy)), DW'(1'b1));
        if (req_rdy != '0)
          checkOutput("grant_only_when_idle", DW'({busy, sm_req_valid, sm_ack_rdy, |ack_valid}), '0);
        if (ack_valid != '0) begin
          if (rsp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_ack: got ack_valid 0x%0h, expected 0", ack_valid);
          end else begin
            r  = rsp_q[0];
            oh = NR'(1) << r.id;
            checkOutput("ack_valid_owner", DW'(ack_valid), DW'(oh));
            checkOutput("grant_id", DW'(grant_id), DW'(r.id));
            checkOutput("ack_err", DW'(ack_err), DW'(r.err));
            checkOutput("ack_data", ack_data, r.data);
            if ((ack_valid & ack_rdy) != '0) void'(rsp_q.pop_front());
          end
        end
      end
    end
  end

  // Absolute bound on the run
  initial begin : watchdog
    #900_000;
    $display("[TB] FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "[TB] global timeout");
  end

  // Directed scenarios followed by randomized batches
  initial begin : stimulus
    logic [NR-1:0] mask;
    int            waited;
    reset_in    = 1'b0;
    req_valid   = '0;
    req_rw      = '0;
    req_addr    = '0;
    req_wr_data = '0;
    ack_rdy     = '0;

    repeat (3) @(negedge clk_in);
    checkOutput("reset_ctrl_outputs",
                DW'({req_rdy, ack_valid, ack_err, sm_req_valid, sm_req_rw, sm_ack_rdy, grant_id, busy}), '0);
    checkOutput("reset_sm_addr", DW'(sm_req_addr), '0);
    checkOutput("reset_sm_wr_data", sm_req_wr_data, '0);
    checkOutput("reset_ack_data", ack_data, '0);
    @(posedge clk_in);
    #2 reset_in = 1'b1;
    model_ptr = NR - 1;

    // Fairness from reset: two full rounds 0,1,2,3,0,1,2,3
    ack_random = 1'b1;
    @(posedge clk_in);
    #1;
    issueMask(4'hF);
    serviceAll();
    issueMask(4'hF);
    serviceAll();

    // Minimum latency read from requester 2
    ack_random     = 1'b0;
    ack_fixed      = '0;
    ack_rdy        = '0;
    force_req_wait = 0;
    force_ack_wait = 0;
    applyStimulus(2, 1'b1, 32'h0000_1000, randLine(), 1'b0);
    @(negedge clk_in);
    checkOutput("lat_req_rdy", DW'(req_rdy), DW'(4'b0100));
    @(posedge clk_in);
    #1 req_valid[2] = 1'b0;
    @(negedge clk_in);
    checkOutput("lat_sm_req", DW'({sm_req_valid, sm_req_rw, sm_req_addr}), DW'({1'b1, 1'b1, 32'h0000_1000}));
    @(negedge clk_in);
    checkOutput("lat_ack_early", DW'(ack_valid), '0);
    @(negedge clk_in);
    checkOutput("lat_ack_valid", DW'(ack_valid), DW'(4'b0100));
    checkOutput("lat_ack_data", ack_data, {32{8'hA5}});
    checkOutput("lat_ack_err", DW'(ack_err), '0);
    ack_random = 1'b1;
    serviceAll();

    // Write from requester 1 with SysMem stalling the request for 5 cycles
    force_req_wait = 5;
    applyStimulus(1, 1'b0, 32'h0000_0040, {8{32'h1234_5678}}, 1'b0);
    @(negedge clk_in);
    checkOutput("wr_req_rdy", DW'(req_rdy), DW'(4'b0010));
    @(posedge clk_in);
    #1 req_valid[1] = 1'b0;
    serviceAll();

    // Watchdog: SysMem never answers, a late ack is ignored
    force_req_wait = 0;
    suppress_ack   = 1'b1;
    ack_random     = 1'b0;
    ack_fixed      = '0;
    ack_rdy        = '0;
    applyStimulus(0, 1'b1, $urandom, randLine(), 1'b1);
    @(negedge clk_in);
    checkOutput("to_req_rdy", DW'(req_rdy), DW'(4'b0001));
    @(posedge clk_in);
    #1 req_valid[0] = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk_in);
      if (c == 8) checkOutput("to_ack_early", DW'(ack_valid), '0);
      if (c == 9) begin
        checkOutput("to_ack_valid", DW'(ack_valid), DW'(4'b0001));
        checkOutput("to_ack_err", DW'(ack_err), DW'(1'b1));
        checkOutput("to_ack_data", ack_data, '0);
      end
    end
    repeat (7) @(negedge clk_in);
    ack_fixed = 4'b0001;
    serviceAll();
    cycle();
    checkOutput("to_back_idle", DW'({busy, ack_valid}), '0);
    suppress_ack   = 1'b0;
    force_req_wait = -1;
    force_ack_wait = -1;

    // Owner stalls the response while everyone else requests
    ack_fixed = '0;
    applyStimulus(2, 1'b1, $urandom, randLine(), 1'b0);
    waited = 0;
    while (ack_valid == '0 && waited < 50) begin
      cycle();
      waited++;
    end
    checkOutput("hold_ack_seen", DW'(ack_valid), DW'(4'b0100));
    issueMask(4'b1011);
    for (int c = 0; c < 10; c++) begin
      cycle();
      checkOutput("hold_no_grant", DW'({req_rdy, ack_valid}), DW'({4'b0000, 4'b0100}));
    end
    ack_random = 1'b1;
    serviceAll();

    // Randomized batches of simultaneous requests
    for (int n = 0; n < 25; n++) begin
      mask = NR'($urandom_range(1, (1 << NR) - 1));
      issueMask(mask);
      serviceAll();
    end

    // Asynchronous reset in the middle of SM_ACK
    force_req_wait = 0;
    force_ack_wait = 5;
    ack_random     = 1'b0;
    ack_fixed      = '0;
    applyStimulus(1, 1'b1, $urandom, randLine(), 1'b0);
    @(negedge clk_in);
    @(posedge clk_in);
    #1 req_valid[1] = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    #2 reset_in = 1'b0;
    #1;
    checkOutput("async_reset_ctrl",
                DW'({req_rdy, ack_valid, ack_err, sm_req_valid, sm_ack_rdy, grant_id, busy}), '0);
    checkOutput("async_reset_sm_addr", DW'(sm_req_addr), '0);
    rsp_q.delete();
    sm_q.delete();
    model_ptr = NR - 1;
    issueMask(4'b1001);
    #1;
    checkOutput("reset_blocks_rdy", DW'(req_rdy), '0);
    repeat (10) @(negedge clk_in);
    force_ack_wait = -1;
    force_req_wait = -1;
    @(posedge clk_in);
    #2 reset_in = 1'b1;
    @(negedge clk_in);
    checkOutput("rr_after_reset", DW'(req_rdy), DW'(4'b0001));
    @(posedge clk_in);
    #1 req_valid[0] = 1'b0;
    ack_random = 1'b1;
    serviceAll();

    repeat (5) @(negedge clk_in);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
